// File: rtl/bf_run_controller.sv
// Brainfuck run controller: program load, data clear, run, done sequencing.
// Optional single-step execution under BF_SINGLE_STEP_EN.
module bf_run_controller #(
    parameter int          IMEM_AW    = 13,
    parameter int          DMEM_AW    = 16,
    parameter int          CYCLE_W    = 40,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 run_start,
    input  logic                 abort,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [15:0]          load_word,
    input  logic                 load_last,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [15:0]          imem_wdata,
    output logic                 dmem_we,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic                 core_reset,
    output logic                 core_step,
    input  logic [2:0]           core_opcode,
    input  logic [7:0]           core_data,
    input  logic                 core_halt,
`ifdef BF_SINGLE_STEP_EN
    input  logic                 step_req,
    input  logic                 step_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYCLE_W-1:0]   cycles,
    output logic [IMEM_AW:0]     load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0]         OP_OUT = 3'd4;
    localparam bit                 TO_EN  = (MAX_CYCLES != 0);
    localparam logic [CYCLE_W-1:0] MAX_C  = CYCLE_W'(MAX_CYCLES);
    localparam logic [IMEM_AW-1:0] I_ONE  = IMEM_AW'(1);
    localparam logic [IMEM_AW:0]   L_ONE  = (IMEM_AW + 1)'(1);
    localparam logic [DMEM_AW-1:0] D_ONE  = DMEM_AW'(1);
    localparam logic [CYCLE_W-1:0] C_ONE  = CYCLE_W'(1);

    state_t               state_q, state_d;
    logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
    logic [IMEM_AW:0]     lcount_q, lcount_d;
    logic [DMEM_AW-1:0]   daddr_q, daddr_d;
    logic [CYCLE_W-1:0]   cycles_q, cycles_d;
    logic                 timeout_q, timeout_d;
    logic                 ovalid_q, ovalid_d;
    logic [7:0]           odata_q, odata_d;

    logic                 stall;
    logic                 step_ok;
    logic [CYCLE_W-1:0]   cyc_inc;

    // A '.' cannot issue while the previous byte is still waiting on the sink.
    assign stall   = (core_opcode == OP_OUT) && ovalid_q && !out_ready;
    assign cyc_inc = cycles_q + C_ONE;

`ifdef BF_SINGLE_STEP_EN
    assign step_ok = !step_mode || step_req;
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        iaddr_d    = iaddr_q;
        lcount_d   = lcount_q;
        daddr_d    = daddr_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        ovalid_d   = ovalid_q;
        odata_d    = odata_q;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        core_reset = 1'b1;
        core_step  = 1'b0;

        if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d  = S_LOAD;
                    iaddr_d  = '0;
                    lcount_d = '0;
                end else if (run_start) begin
                    state_d   = S_CLEAR;
                    daddr_d   = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    imem_we  = 1'b1;
                    iaddr_d  = iaddr_q + I_ONE;
                    lcount_d = lcount_q + L_ONE;
                    if (load_last || (&iaddr_q)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                dmem_we = 1'b1;
                daddr_d = daddr_q + D_ONE;
                if (&daddr_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                core_reset = 1'b0;
                if (core_halt) begin
                    state_d = S_DONE;
                end else if (!stall && step_ok) begin
                    core_step = 1'b1;
                    cycles_d  = cyc_inc;
                    if (core_opcode == OP_OUT) begin
                        odata_d  = core_data;
                        ovalid_d = 1'b1;
                    end
                    if (TO_EN && (cyc_inc == MAX_C)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes bookkeeping and suppresses every side effect this cycle.
        if (abort) begin
            state_d    = S_IDLE;
            iaddr_d    = iaddr_q;
            lcount_d   = lcount_q;
            daddr_d    = daddr_q;
            cycles_d   = cycles_q;
            timeout_d  = timeout_q;
            odata_d    = odata_q;
            ovalid_d   = 1'b0;
            load_ready = 1'b0;
            imem_we    = 1'b0;
            dmem_we    = 1'b0;
            core_step  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            iaddr_q   <= '0;
            lcount_q  <= '0;
            daddr_q   <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            ovalid_q  <= 1'b0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            iaddr_q   <= iaddr_d;
            lcount_q  <= lcount_d;
            daddr_q   <= daddr_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            ovalid_q  <= ovalid_d;
            odata_q   <= odata_d;
        end
    end

    assign imem_addr  = iaddr_q;
    assign imem_wdata = load_word;
    assign dmem_addr  = daddr_q;
    assign out_valid  = ovalid_q;
    assign out_data   = odata_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_CLEAR) ||
                        (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;
    assign load_count = lcount_q;

endmodule

// File: tb/tb_bf_run_controller.sv
// Bench for bf_run_controller with a behavioural Brainfuck-like core model.
// Small data memory keeps the clear phase short.
module tb_bf_run_controller;

    localparam int IAW = 13;
    localparam int DAW = 10;
    localparam int CW  = 40;

    logic            clock = 1'b0;
    logic            reset;
    logic            load_start, run_start, abort;
    logic            load_valid, load_ready, load_last;
    logic [15:0]     load_word;
    logic            imem_we;
    logic [IAW-1:0]  imem_addr;
    logic [15:0]     imem_wdata;
    logic            dmem_we;
    logic [DAW-1:0]  dmem_addr;
    logic            core_reset, core_step;
    logic [2:0]      core_opcode;
    logic [7:0]      core_data;
    logic            core_halt;
    logic            out_valid, out_ready;
    logic [7:0]      out_data;
    logic            busy, done, timeout;
    logic [CW-1:0]   cycles;
    logic [IAW:0]    load_count;
`ifdef BF_SINGLE_STEP_EN
    logic            step_req = 1'b0;
    logic            step_mode = 1'b0;
`endif

    always #5 clock = ~clock;

    bf_run_controller #(
        .IMEM_AW(IAW), .DMEM_AW(DAW), .CYCLE_W(CW), .MAX_CYCLES(100)
    ) dut (
        .clock(clock), .reset(reset),
        .load_start(load_start), .run_start(run_start), .abort(abort),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_word(load_word), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .core_reset(core_reset), .core_step(core_step),
        .core_opcode(core_opcode), .core_data(core_data),
        .core_halt(core_halt),
`ifdef BF_SINGLE_STEP_EN
        .step_req(step_req), .step_mode(step_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .timeout(timeout),
        .cycles(cycles), .load_count(load_count)
    );

    // Core model: op0 adds arg[7:0] to cell, op7 jumps to arg, word 0 halts.
    logic [15:0]    imem [0:(1<<IAW)-1];
    logic [7:0]     dmem [0:(1<<DAW)-1];
    logic [IAW-1:0] pc;
    logic [DAW-1:0] dp;
    logic [15:0]    cur;

    assign cur         = imem[pc];
    assign core_opcode = cur[15:13];
    assign core_halt   = (cur == 16'h0000);
    assign core_data   = dmem[dp];

    always @(posedge clock) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (dmem_we) dmem[dmem_addr] <= 8'h00;
        if (core_reset) begin
            pc <= '0;
            dp <= '0;
        end else if (core_step) begin
            case (cur[15:13])
                3'd0: begin
                    dmem[dp] <= dmem[dp] + cur[7:0];
                    pc <= pc + 1'b1;
                end
                3'd7: pc <= cur[IAW-1:0];
                default: pc <= pc + 1'b1;
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  sb_q [$];
    logic [15:0] prog_q [$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output scoreboard: a byte is consumed at the edge following valid&&ready.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_byte", {56'd0, out_data}, 64'hFFFF);
            end else begin
                check("sb_byte", {56'd0, out_data}, {56'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_prog();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < prog_q.size(); i++) begin
            load_valid = 1'b1;
            load_word  = prog_q[i];
            load_last  = (i == prog_q.size() - 1);
            @(negedge clock);
            check("lp_we", {63'd0, imem_we}, 64'd1);
            check("lp_addr", {51'd0, imem_addr}, i);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clock);
        check("lp_idle", {63'd0, busy}, 64'd0);
        check("lp_count", {50'd0, load_count}, prog_q.size());
    endtask

    task automatic pulse_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        @(negedge clock);
        while (!done && k < max) begin
            @(negedge clock);
            k++;
        end
        check("wait_done", {63'd0, done}, 64'd1);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] w;
        logic        last;
        logic        exp_we;
        logic [12:0] exp_addr;
    } lvec_t;
    lvec_t tbl [4];

    initial begin
        int clr_n, clr_bad, stalls, hits, k;
        for (int i = 0; i < (1 << IAW); i++) imem[i] = 16'h0000;
        reset = 1'b1; load_start = 0; run_start = 0; abort = 0;
        load_valid = 0; load_word = 0; load_last = 0; out_ready = 1'b1;

        tbl[0] = '{1'b1, 16'h0005, 1'b0, 1'b1, 13'd0};
        tbl[1] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 13'd1};
        tbl[2] = '{1'b1, 16'h8000, 1'b0, 1'b1, 13'd1};
        tbl[3] = '{1'b1, 16'h0000, 1'b1, 1'b1, 13'd2};

        tick();
        tick();
        @(negedge clock);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_core_reset", {63'd0, core_reset}, 64'd1);
        check("rst_en", {60'd0, imem_we, dmem_we, core_step, load_ready}, 64'd0);
        check("rst_out", {55'd0, out_valid, out_data}, 64'd0);
        check("rst_cnt", {10'd0, timeout, cycles, load_count}, 64'd0);
        tick();
        reset = 1'b0;

        // Table-driven load with a bubble beat.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = tbl[i].v;
            load_word  = tbl[i].w;
            load_last  = tbl[i].last;
            @(negedge clock);
            check("tb_ready", {63'd0, load_ready}, 64'd1);
            check("tb_we", {63'd0, imem_we}, {63'd0, tbl[i].exp_we});
            check("tb_addr", {51'd0, imem_addr}, {51'd0, tbl[i].exp_addr});
            if (tbl[i].exp_we)
                check("tb_wdata", {48'd0, imem_wdata}, {48'd0, tbl[i].w});
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clock);
        check("tb_idle", {63'd0, busy}, 64'd0);
        check("tb_count", {50'd0, load_count}, 64'd3);

        // Run "+5 . halt" and measure the clear phase.
        sb_q.push_back(8'h05);
        tick();
        pulse_run();
        clr_n = 0;
        clr_bad = 0;
        @(negedge clock);
        while (dmem_we && clr_n < 5000) begin
            if (dmem_addr != DAW'(clr_n)) clr_bad++;
            if (!core_reset) clr_bad++;
            clr_n++;
            @(negedge clock);
        end
        check("clr_len", clr_n, 64'd1 << DAW);
        check("clr_addr_seq", clr_bad, 64'd0);
        check("run_core_rst", {63'd0, core_reset}, 64'd0);
        wait_done(100);
        check("r1_cycles", cycles, 64'd2);
        check("r1_timeout", {63'd0, timeout}, 64'd0);
        check("r1_core_rst", {63'd0, core_reset}, 64'd1);

        // Backpressure with two back-to-back outputs.
        tick();
        prog_q = '{16'h0005, 16'h8000, 16'h0001, 16'h8000, 16'h0000};
        load_prog();
        sb_q.push_back(8'h05);
        sb_q.push_back(8'h06);
        tick();
        out_ready = 1'b0;
        pulse_run();
        k = 0;
        @(negedge clock);
        while (!(core_reset == 1'b0 && core_opcode == 3'd4 && out_valid &&
                 !core_step) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("bp_stall_seen", {63'd0, out_valid}, 64'd1);
        stalls = 0;
        repeat (10) begin
            if (!core_step) stalls++;
            tick();
        end
        check("bp_stalls", stalls, 64'd10);
        check("bp_cycles_hold", cycles, 64'd3);
        out_ready = 1'b1;
        wait_done(100);
        check("bp_cycles", cycles, 64'd4);

        // Pending byte in DONE, then abort mid-clear.
        tick();
        prog_q = '{16'h0005, 16'h8000, 16'h0000};
        load_prog();
        tick();
        out_ready = 1'b0;
        pulse_run();
        wait_done(3000);
        check("pend_valid", {55'd0, out_valid, out_data}, {55'd0, 1'b1, 8'h05});
        tick();
        pulse_run();
        repeat (20) tick();
        check("ab_in_clear", {63'd0, dmem_we}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        check("ab_clr_idle", {62'd0, busy, done}, 64'd0);
        check("ab_clr_we", {63'd0, dmem_we}, 64'd0);
        check("ab_clr_ov", {63'd0, out_valid}, 64'd0);
        tick();
        pulse_run();
        @(negedge clock);
        check("ab_restart", {53'd0, dmem_we, dmem_addr}, {53'd0, 1'b1, 10'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b1;

        // Abort mid-load.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_word  = 16'h1234;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        check("ab_ld_idle", {63'd0, busy}, 64'd0);
        check("ab_ld_we", {62'd0, imem_we, load_ready}, 64'd0);
        tick();
        load_valid = 1'b0;

        // Infinite loop reaches the step limit.
        prog_q = '{16'hE000};
        load_prog();
        tick();
        pulse_run();
        wait_done(3000);
        check("to_flag", {63'd0, timeout}, 64'd1);
        check("to_cycles", cycles, 64'd100);

        // Simultaneous starts in DONE, then a full unterminated load.
        tick();
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        @(negedge clock);
        check("both_load", {61'd0, busy, load_ready, dmem_we}, 64'd6);
        tick();
        hits = 0;
        for (int i = 0; i < (1 << IAW); i++) begin
            load_valid = 1'b1;
            load_word  = i[15:0];
            @(negedge clock);
            if (imem_we && imem_addr == IAW'(i) && imem_wdata == i[15:0]) hits++;
            tick();
        end
        @(negedge clock);
        check("full_hits", hits, 64'd1 << IAW);
        check("full_exit", {62'd0, busy, imem_we}, 64'd0);
        check("full_count", {50'd0, load_count}, 64'd1 << IAW);
        load_valid = 1'b0;

        tick();
        check("sb_drained", sb_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
